// File: rtl/tone_sequencer.sv
// tone_sequencer
//   Steps through a fixed C-major table of note divisors and drives the 32-bit divisor input
//   of a downstream frequency divider. Each note sounds for NOTE_TICKS clk cycles, followed by
//   GAP_TICKS cycles of silence (skipped when GAP_TICKS is 0), then the next note starts.
//   Divisor entry i = CLK_HZ/(2*f_i) - 1, which suits a divider that toggles when its count
//   reaches the divisor (output period 2*(divisor+1)).
//
// Optional build macro:
//   TONE_SEQ_LOOP_EN - adds the loop input; when high at the end of the last note, playback
//                      wraps to note 0 instead of finishing.
//
// Ports:
//   clk      in   system clock (the divided clock is never used as a clock here)
//   reset    in   synchronous, active-high reset
//   start    in   one-cycle request to begin playback from note 0 (ignored while busy)
//   stop     in   abort playback and return to idle; wins over start
//   loop     in   wrap request, sampled at the end of the last note (TONE_SEQ_LOOP_EN only)
//   divisor  out  registered divisor for the frequency divider
//   tone_en  out  high while a note is sounding
//   note_idx out  index of the current/last note
//   busy     out  high while playing or in a gap
//   done     out  one-cycle pulse on normal completion

module tone_sequencer #(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned NUM_NOTES  = 8,
   parameter int unsigned NOTE_TICKS = 25_000_000,
   parameter int unsigned GAP_TICKS  = 2_500_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        stop,
`ifdef TONE_SEQ_LOOP_EN
   input  logic        loop,
`endif
   output logic [31:0] divisor,
   output logic        tone_en,
   output logic [2:0]  note_idx,
   output logic        busy,
   output logic        done
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PLAY = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   localparam int unsigned MAX_TICKS = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
   localparam int unsigned CNT_W     = $clog2(MAX_TICKS + 1);

   localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_TICKS - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
   localparam logic [2:0]       LAST_IDX  = 3'(NUM_NOTES - 1);

   function automatic logic [31:0] note_div(input int unsigned idx);
      int unsigned f;
      case (idx)
         0:       f = 262;
         1:       f = 294;
         2:       f = 330;
         3:       f = 349;
         4:       f = 392;
         5:       f = 440;
         6:       f = 494;
         default: f = 523;
      endcase
      return 32'(CLK_HZ / (2 * f) - 1);
   endfunction

   localparam logic [31:0] NOTE_TABLE [8] = '{
      note_div(0), note_div(1), note_div(2), note_div(3),
      note_div(4), note_div(5), note_div(6), note_div(7)
   };

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [31:0]      div_q, div_d;
   logic             tone_q, tone_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             loop_req;
   logic             note_done;
   logic [2:0]       idx_next;

`ifdef TONE_SEQ_LOOP_EN
   assign loop_req = loop;
`else
   assign loop_req = 1'b0;
`endif

   // A note (sound plus optional gap) is complete on the last cycle of whichever phase ends it.
   assign note_done = ((state_q == ST_PLAY) && (cnt_q == NOTE_LAST) && (GAP_TICKS == 0)) ||
                      ((state_q == ST_GAP) && (cnt_q == GAP_LAST));
   assign idx_next  = idx_q + 3'd1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      div_d   = div_q;
      tone_d  = tone_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      if (stop) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         idx_d   = 3'd0;
         div_d   = NOTE_TABLE[0];
         tone_d  = 1'b0;
         busy_d  = 1'b0;
      end else if (state_q == ST_IDLE) begin
         if (start) begin
            state_d = ST_PLAY;
            cnt_d   = '0;
            idx_d   = 3'd0;
            div_d   = NOTE_TABLE[0];
            tone_d  = 1'b1;
            busy_d  = 1'b1;
         end
      end else if (note_done) begin
         cnt_d = '0;
         if (idx_q != LAST_IDX) begin
            state_d = ST_PLAY;
            idx_d   = idx_next;
            div_d   = NOTE_TABLE[idx_next];
            tone_d  = 1'b1;
         end else if (loop_req) begin
            state_d = ST_PLAY;
            idx_d   = 3'd0;
            div_d   = NOTE_TABLE[0];
            tone_d  = 1'b1;
         end else begin
            // Normal end: note_idx and divisor keep the last note's values.
            state_d = ST_IDLE;
            tone_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
      end else if ((state_q == ST_PLAY) && (cnt_q == NOTE_LAST)) begin
         // Only reachable with a non-zero gap; the divisor holds through the silence.
         state_d = ST_GAP;
         cnt_d   = '0;
         tone_d  = 1'b0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= 3'd0;
         div_q   <= NOTE_TABLE[0];
         tone_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         div_q   <= div_d;
         tone_q  <= tone_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign divisor  = div_q;
   assign tone_en  = tone_q;
   assign note_idx = idx_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule
